fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage upstream of the combinational instruction memory.
//  - Holds the PC, drives the memory address, selects the next PC (sequential/branch/jump/jr).
//  - Captures the returned word into the IF/ID register consumed by the controller/decoder.
//  - A redirect flushes the wrong-path word as a NOP bubble.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  NOP_INSTR   32'h0000_0000  word placed in IF/ID on reset/flush (sll $0,$0,0)
//  EXC_VECTOR  32'h0000_0080  fetch-exception target (FETCH_ALIGN_CHECK_EN only)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  stall          in   1   hazard unit: hold PC and IF/ID
//  pc_src         in   2   00 PC+4, 01 branch, 10 jump, 11 jr (decided in ID)
//  branch_target  in   32  id_pc_plus4 + (sext(imm16)<<2), computed in ID
//  jump_index     in   26  instr[25:0] of j/jal in ID
//  jr_target      in   32  rs value for jr
//  imem_addr      out  32  instruction-memory address (= PC, combinational)
//  imem_data      in   32  instruction word returned same cycle
//  id_instr       out  32  IF/ID instruction
//  id_pc_plus4    out  32  IF/ID PC+4 (jal link value, branch base)
//  id_valid       out  1   IF/ID holds a real fetched instruction
//  fetch_exc      out  1   one-cycle misaligned-target pulse (0 without macro)
//  bad_addr       out  32  last misaligned target (0 without macro)
// BEHAVIOUR
//  - Reset (sync, highest priority, also mid-stall/redirect):
//    pc=RESET_PC, id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0, fetch_exc=0, bad_addr=0.
//  - imem_addr = pc, no register, so the fetched word is valid in the same cycle.
//  - Priority per edge: reset > stall > redirect (pc_src!=00) > sequential.
//  - stall=1: pc and all IF/ID outputs hold; pc_src is ignored. fetch_exc=0.
//  - Sequential (pc_src=00):
//    pc<=pc+4; id_instr<=imem_data; id_pc_plus4<=pc+4; id_valid<=1.
//  - Redirect: next = 01 branch_target | 10 {id_pc_plus4[31:28],jump_index,2'b00} | 11 jr_target.
//    pc<=next; id_instr<=NOP_INSTR; id_valid<=0; id_pc_plus4<=pc+4. The word fetched that cycle is discarded.
//  - Fetch latency: address out in cycle N, word in id_instr after edge N; one bubble per taken redirect.
//  - Arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, with no flag.
//  - Back-to-back redirects are legal: each cycle loads a new target and keeps the bubble.
//  - A self-branch (target==pc) loops forever, inserting a bubble every cycle.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    - A redirect target with [1:0]!=0 sets pc<=EXC_VECTOR, fetch_exc=1 for one cycle, bad_addr<=target.
//    - IF/ID flushes as for a normal redirect. Sequential PCs never fault.
//  Undefined:
//    - Target bits [1:0] are forced to 00 on load.
//    - fetch_exc and bad_addr are tied to 0.
// TESTING
//  1 reset 2 cycles, release -> imem_addr=0, id_valid=0.
//    Next edge: pc=4, id_instr=imem_data(0x20040003), id_pc_plus4=4, id_valid=1.
//  2 pc=4, pc_src=10, jump_index=26'h3, id_pc_plus4=8 -> pc=0x0C, id_instr=NOP, id_valid=0.
//    Next edge: sequential fetch from 0x0C.
//  3 pc=8, pc_src=01, branch_target=8 -> pc stays 8 each cycle, id_valid=0 throughout (self-loop).
//  4 stall=1 for 3 cycles with pc_src=11, jr_target=0x40 -> pc, id_instr, id_valid unchanged.
//    Stall drops with pc_src=11 -> pc=0x40.
//  5 pc_src=11 with stall=0, reset=1 on the same edge -> pc=RESET_PC, id_instr=NOP, id_valid=0.
//  6 jr_target=0x0000_000A:
//    - macro on -> pc=0x80, fetch_exc=1 for 1 cycle, bad_addr=0x0A.
//    - macro off -> pc=0x08, fetch_exc=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage ahead of a combinational instruction memory.
// Holds the PC, selects the next PC (sequential / branch / jump / jr), and
// captures the fetched word into the IF/ID register. A taken redirect replaces
// the wrong-path word with a NOP bubble.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target vectors to EXC_VECTOR, pulses
//               fetch_exc for one cycle and records the target in bad_addr.
//   undefined : target bits [1:0] are cleared on load; fetch_exc/bad_addr are 0.
//
// Flow control: there is no valid/ready handshake here. id_valid only qualifies
// the IF/ID contents (1 = real fetched word, 0 = bubble). stall freezes the PC
// and IF/ID together; the consumer must not expect new data while it is high.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
`ifdef FETCH_ALIGN_CHECK_EN
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
`endif
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_exc,
  output logic [31:0] bad_addr
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        redirect;

  // Memory address is the PC itself so the word returns in the same cycle.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign redirect  = (pc_src != 2'b00);

  // Raw redirect target as decided in ID.
  always_comb begin
    redirect_target = 32'h0000_0000;
    case (pc_src)
      2'b01:   redirect_target = branch_target;
      2'b10:   redirect_target = {id_pc_plus4[31:28], jump_index, 2'b00};
      2'b11:   redirect_target = jr_target;
      default: redirect_target = 32'h0000_0000;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);

  // Next PC: sequential, redirect target, or exception vector on a bad target.
  always_comb begin
    next_pc = pc_plus4;
    if (redirect) begin
      next_pc = misaligned ? EXC_VECTOR : redirect_target;
    end
  end

  // Exception pulse and faulting-address capture; stall suppresses the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_exc <= 1'b0;
      bad_addr  <= 32'h0000_0000;
    end else if (stall) begin
      fetch_exc <= 1'b0;
    end else begin
      fetch_exc <= misaligned;
      if (misaligned) begin
        bad_addr <= redirect_target;
      end
    end
  end
`else
  // Next PC: sequential or redirect target with the byte offset cleared.
  always_comb begin
    next_pc = pc_plus4;
    if (redirect) begin
      next_pc = redirect_target & 32'hFFFF_FFFC;
    end
  end

  assign fetch_exc = 1'b0;
  assign bad_addr  = 32'h0000_0000;
`endif

  // PC and IF/ID register: reset > stall > redirect (bubble) > sequential.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      id_instr    <= id_instr;
      id_pc_plus4 <= id_pc_plus4;
      id_valid    <= id_valid;
    end else if (redirect) begin
      pc          <= next_pc;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b0;
    end else begin
      pc          <= next_pc;
      id_instr    <= imem_data;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven vectors for fetch_stage with an expected-value
// queue, plus a random-stall sequential run. The instruction memory is a small
// address-derived function so every fetched word is predictable.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fetch_exc;
  logic [31:0] bad_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // expected: {pc, instr, pc_plus4, valid, exc, bad}
  localparam int EW = 32 * 4 + 2;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  src;
    logic [31:0] bt;
    logic [25:0] ji;
    logic [31:0] jr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_exc;
    logic [31:0] e_bad;
  } vec_t;

  localparam int NV = 26;
  vec_t vec[NV];

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid),
    .fetch_exc     (fetch_exc),
    .bad_addr      (bad_addr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2004_0003 : (32'h1000_0000 | a);
  endfunction

  // combinational instruction memory model
  assign imem_data = mem_word(imem_addr);

  function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] src,
                              input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid,
                              input logic e_exc, input logic [31:0] e_bad);
    vec_t v;
    v.rst = rst; v.stl = stl; v.src = src; v.bt = bt; v.ji = ji; v.jr = jr;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_exc = e_exc; v.e_bad = e_bad;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply one vector's inputs and push its expectation
  task automatic drive(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    stall         = v.stl;
    pc_src        = v.src;
    branch_target = v.bt;
    jump_index    = v.ji;
    jr_target     = v.jr;
    exp_q.push_back({v.e_pc, v.e_instr, v.e_pc4, v.e_valid, v.e_exc, v.e_bad});
  endtask

  // scoreboard: after the edge, pop and compare
  task automatic sample(input string tag);
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s queue: empty, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " pc"},       imem_addr,           e[129:98]);
      check({tag, " instr"},    id_instr,            e[97:66]);
      check({tag, " pc_plus4"}, id_pc_plus4,         e[65:34]);
      check({tag, " valid"},    {31'h0, id_valid},   {31'h0, e[33]});
      check({tag, " exc"},      {31'h0, fetch_exc},  {31'h0, e[32]});
      check({tag, " bad"},      bad_addr,            e[31:0]);
    end
  endtask

  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        s;

    reset = 1'b1; stall = 1'b0; pc_src = 2'b00;
    branch_target = '0; jump_index = '0; jr_target = '0;

    //           rst  stl  src    bt          ji      jr            pc            instr         pc4           v     exc   bad
    vec[0]  = mk(1'b1,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 32'h0);
    vec[1]  = mk(1'b1,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 32'h0);
    vec[2]  = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h4,       32'h2004_0003,32'h4,      1'b1, 1'b0, 32'h0);
    vec[3]  = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h8,       32'h1000_0004,32'h8,      1'b1, 1'b0, 32'h0);
    // jump to index 3 -> 0x0C, bubble
    vec[4]  = mk(1'b0,1'b0,2'b10,32'h0,      26'h3, 32'h0,       32'hC,       32'h0,       32'hC,       1'b0, 1'b0, 32'h0);
    vec[5]  = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h10,      32'h1000_000C,32'h10,     1'b1, 1'b0, 32'h0);
    // branch to 8, then self-loop at 8
    vec[6]  = mk(1'b0,1'b0,2'b01,32'h8,      26'h0, 32'h0,       32'h8,       32'h0,       32'h14,      1'b0, 1'b0, 32'h0);
    vec[7]  = mk(1'b0,1'b0,2'b01,32'h8,      26'h0, 32'h0,       32'h8,       32'h0,       32'hC,       1'b0, 1'b0, 32'h0);
    vec[8]  = mk(1'b0,1'b0,2'b01,32'h8,      26'h0, 32'h0,       32'h8,       32'h0,       32'hC,       1'b0, 1'b0, 32'h0);
    vec[9]  = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'hC,       32'h1000_0008,32'hC,      1'b1, 1'b0, 32'h0);
    // stall 3 cycles with a pending jr
    vec[10] = mk(1'b0,1'b1,2'b11,32'h0,      26'h0, 32'h40,      32'hC,       32'h1000_0008,32'hC,      1'b1, 1'b0, 32'h0);
    vec[11] = mk(1'b0,1'b1,2'b11,32'h0,      26'h0, 32'h40,      32'hC,       32'h1000_0008,32'hC,      1'b1, 1'b0, 32'h0);
    vec[12] = mk(1'b0,1'b1,2'b11,32'h0,      26'h0, 32'h40,      32'hC,       32'h1000_0008,32'hC,      1'b1, 1'b0, 32'h0);
    vec[13] = mk(1'b0,1'b0,2'b11,32'h0,      26'h0, 32'h40,      32'h40,      32'h0,       32'h10,      1'b0, 1'b0, 32'h0);
    vec[14] = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h44,      32'h1000_0040,32'h44,     1'b1, 1'b0, 32'h0);
    // reset wins over redirect and over stall
    vec[15] = mk(1'b1,1'b0,2'b11,32'h0,      26'h0, 32'h40,      32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 32'h0);
    vec[16] = mk(1'b1,1'b1,2'b00,32'h0,      26'h0, 32'h0,       32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 32'h0);
    vec[17] = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h4,       32'h2004_0003,32'h4,      1'b1, 1'b0, 32'h0);
    // misaligned jr target 0x0A
`ifdef FETCH_ALIGN_CHECK_EN
    vec[18] = mk(1'b0,1'b0,2'b11,32'h0,      26'h0, 32'hA,       32'h80,      32'h0,       32'h8,       1'b0, 1'b1, 32'hA);
    vec[19] = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h84,      32'h1000_0080,32'h84,     1'b1, 1'b0, 32'hA);
`else
    vec[18] = mk(1'b0,1'b0,2'b11,32'h0,      26'h0, 32'hA,       32'h8,       32'h0,       32'h8,       1'b0, 1'b0, 32'h0);
    vec[19] = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'hC,       32'h1000_0008,32'hC,      1'b1, 1'b0, 32'h0);
`endif
    vec[20] = mk(1'b1,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h0,       32'h0,       32'h0,       1'b0, 1'b0, 32'h0);
    // wrap at the top of the address space
    vec[21] = mk(1'b0,1'b0,2'b11,32'h0,      26'h0, 32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,     32'h4,       1'b0, 1'b0, 32'h0);
    vec[22] = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'h0,       32'hFFFF_FFFC,32'h0,      1'b1, 1'b0, 32'h0);
    // jump keeps the region bits of id_pc_plus4
    vec[23] = mk(1'b0,1'b0,2'b11,32'h0,      26'h0, 32'hF000_0000,32'hF000_0000,32'h0,     32'h4,       1'b0, 1'b0, 32'h0);
    vec[24] = mk(1'b0,1'b0,2'b00,32'h0,      26'h0, 32'h0,       32'hF000_0004,32'hF000_0000,32'hF000_0004,1'b1,1'b0,32'h0);
    vec[25] = mk(1'b0,1'b0,2'b10,32'h0,      26'h5, 32'h0,       32'hF000_0014,32'h0,      32'hF000_0008,1'b0,1'b0,32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i]);
      sample($sformatf("vec%0d", i));
      // address must be visible right after reset is released, before any fetch edge
      if (i == 1) begin
        check("post_reset imem_addr", imem_addr, 32'h0);
        check("post_reset id_valid", {31'h0, id_valid}, 32'h0);
      end
    end

    // random stall pattern over a sequential run from a clean reset
    drive(mk(1'b1,1'b0,2'b00,32'h0,26'h0,32'h0, 32'h0,32'h0,32'h0,1'b0,1'b0,32'h0));
    sample("rs_reset");
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      s = ($urandom_range(0, 2) == 0);
      if (!s) begin
        m_instr = mem_word(m_pc);
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
        m_valid = 1'b1;
      end
      drive(mk(1'b0, s, 2'b00, 32'h0, 26'h0, 32'h0, m_pc, m_instr, m_pc4, m_valid, 1'b0, 32'h0));
      sample($sformatf("rs%0d", k));
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover queue: %0d entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
